// File: rtl/apb_master_bridge.sv
// APB requester bridge: turns single valid/ready read/write commands into
// IDLE -> SETUP -> ACCESS bus transfers and reports each completion with a
// registered one-cycle response pulse. An optional watchdog ends transfers
// that sit in ACCESS too long without p_ready.
module apb_master_bridge #(
    parameter int A_WIDTH        = 8,
    parameter int D_WIDTH        = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               p_clk,
    input  logic               p_rst,
    // command side
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [A_WIDTH-1:0] cmd_addr,
    input  logic [D_WIDTH-1:0] cmd_wdata,
    // response side
    output logic               rsp_valid,
    output logic [D_WIDTH-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               rsp_timeout,
    // APB side
    output logic               p_sel,
    output logic               p_enable,
    output logic               p_write,
    output logic [A_WIDTH-1:0] p_addr,
    output logic [D_WIDTH-1:0] wr_data,
    input  logic [D_WIDTH-1:0] rd_data,
    input  logic               p_ready,
    input  logic               p_slverr,
    // state export for bound assertion modules
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // The wait counter only ever needs to hold TIMEOUT_CYCLES-1: the cycle
    // that would make it reach TIMEOUT_CYCLES is the terminating cycle.
    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);

    state_t             cur_state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               complete;
    logic               timed_out;
    logic               accept;

    assign state  = cur_state;
    assign accept = cmd_valid && cmd_ready;

    // State register; reset takes the bus back to IDLE immediately.
    always_ff @(posedge p_clk or posedge p_rst) begin
        if (p_rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            cur_state <= S_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state decode and bus/handshake outputs from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state = cur_state;
        p_sel      = 1'b0;
        p_enable   = 1'b0;
        cmd_ready  = 1'b0;
        complete   = 1'b0;
        timed_out  = 1'b0;
        case (cur_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                p_sel      = 1'b1;
                next_state = S_ACCESS;
            end
            S_ACCESS: begin
                p_sel    = 1'b1;
                p_enable = 1'b1;
                if (p_ready) begin
                    // p_ready beats the timeout threshold in the same cycle.
                    complete   = 1'b1;
                    cmd_ready  = 1'b1;
                    next_state = cmd_valid ? S_SETUP : S_IDLE;
                end else if (TO_EN && (wait_cnt == TO_LAST_C)) begin
                    timed_out  = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: begin
                // Unused encoding: outputs stay deasserted, recover to IDLE.
                next_state = S_IDLE;
            end
        endcase
        // IDLE is also the reset state, so cmd_ready must be masked while
        // reset is held to keep every output low.
        if (p_rst) begin
            cmd_ready = 1'b0;
        end
    end

    // Wait-state counter: counts ACCESS cycles without p_ready, clears on exit.
    always_ff @(posedge p_clk or posedge p_rst) begin
        if (p_rst) begin
            wait_cnt <= '0;
        end else if (TO_EN && (cur_state == S_ACCESS) && !p_ready && !timed_out) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Transfer registers: loaded only at an accept edge, held otherwise.
    always_ff @(posedge p_clk or posedge p_rst) begin
        if (p_rst) begin
            p_write <= 1'b0;
            p_addr  <= '0;
            wr_data <= '0;
        end else if (accept) begin
            p_write <= cmd_write;
            p_addr  <= cmd_addr;
            wr_data <= cmd_wdata;
        end
    end

    // Response pulse: registered at the completing or terminating edge.
    always_ff @(posedge p_clk or posedge p_rst) begin
        if (p_rst) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= complete || timed_out;
            rsp_rdata   <= (complete && !p_write) ? rd_data : '0;
            rsp_err     <= (complete && p_slverr) || timed_out;
            rsp_timeout <= timed_out;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, random
// transfers against a transaction-level model, and hand-written sequences
// for reset, back-to-back and mid-transfer reset behaviour.
module tb_apb_master_bridge;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          p_clk;
    logic          p_rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          p_sel;
    logic          p_enable;
    logic          p_write;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          p_ready;
    logic          p_slverr;
    logic [1:0]    state;

    int checks   = 0;
    int failures = 0;

    apb_master_bridge #(
        .A_WIDTH       (AW),
        .D_WIDTH       (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .p_clk      (p_clk),
        .p_rst      (p_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .p_sel      (p_sel),
        .p_enable   (p_enable),
        .p_write    (p_write),
        .p_addr     (p_addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .p_ready    (p_ready),
        .p_slverr   (p_slverr),
        .state      (state)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;      // ACCESS cycles with p_ready=0 before ready
        logic [DW-1:0] rdata;      // rd_data presented with p_ready
        logic          slverr;     // p_slverr presented with p_ready
        logic          exp_err;
        logic          exp_to;
        logic [DW-1:0] exp_rdata;
        int            exp_access; // ACCESS cycles the transfer must last
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input int waits, input logic [DW-1:0] rd, input logic se,
                                input logic ee, input logic et, input logic [DW-1:0] er,
                                input int n);
        vec_t v;
        v.write = w;  v.addr = a;  v.wdata = d;  v.waits = waits;
        v.rdata = rd; v.slverr = se;
        v.exp_err = ee; v.exp_to = et; v.exp_rdata = er; v.exp_access = n;
        return v;
    endfunction

    // Transaction-level reference: outcome and ACCESS length from the
    // slave's wait count alone.
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        logic to = (v.waits >= TO);
        r.exp_access = to ? TO : v.waits + 1;
        r.exp_to     = to;
        r.exp_err    = to || v.slverr;
        r.exp_rdata  = (to || v.write) ? '0 : v.rdata;
        return r;
    endfunction

    task automatic check_stable(input string tag, input vec_t v);
        check({tag, "_p_addr"},  p_addr,  v.addr);
        check({tag, "_p_write"}, p_write, v.write);
        check({tag, "_wr_data"}, wr_data, v.wdata);
    endtask

    task automatic run_xfer(input vec_t v, input string tag);
        @(negedge p_clk);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        p_ready = 1'b0; p_slverr = 1'b0;
        #1;
        check({tag, "_idle_ready"}, cmd_ready, 1);
        check({tag, "_idle_state"}, state, 0);
        @(posedge p_clk);
        // SETUP cycle; scramble command inputs to prove they are not followed
        @(negedge p_clk);
        cmd_valid = 1'b0; cmd_write = ~v.write; cmd_addr = ~v.addr; cmd_wdata = DW'($urandom);
        #1;
        check({tag, "_setup_state"}, state, 1);
        check({tag, "_setup_sel"}, p_sel, 1);
        check({tag, "_setup_en"}, p_enable, 0);
        check({tag, "_setup_ready"}, cmd_ready, 0);
        check_stable({tag, "_setup"}, v);
        for (int i = 0; i < v.exp_access; i++) begin
            @(negedge p_clk);
            p_ready  = (i == v.waits);
            rd_data  = (i == v.waits) ? v.rdata  : DW'($urandom);
            p_slverr = (i == v.waits) ? v.slverr : 1'($urandom);
            #1;
            check({tag, "_acc_state"}, state, 2);
            check({tag, "_acc_sel"}, p_sel, 1);
            check({tag, "_acc_en"}, p_enable, 1);
            check({tag, "_acc_ready"}, cmd_ready, p_ready);
            check({tag, "_acc_rsp_valid"}, rsp_valid, 0);
            check_stable({tag, "_acc"}, v);
        end
        @(negedge p_clk);
        p_ready = 1'b0; p_slverr = 1'b0;
        #1;
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, "_rsp_err"}, rsp_err, v.exp_err);
        check({tag, "_rsp_timeout"}, rsp_timeout, v.exp_to);
        check({tag, "_rsp_state"}, state, 0);
        check({tag, "_rsp_sel"}, p_sel, 0);
        check({tag, "_rsp_en"}, p_enable, 0);
        check_stable({tag, "_idle_hold"}, v);
        @(negedge p_clk);
        #1;
        check({tag, "_post_valid"}, rsp_valid, 0);
        check({tag, "_post_rdata"}, rsp_rdata, 0);
        check({tag, "_post_err"}, rsp_err, 0);
        check({tag, "_post_timeout"}, rsp_timeout, 0);
    endtask

    vec_t vecs[7];

    initial begin
        vec_t v;

        vecs[0] = mk(1'b1, 8'h45, 8'hA5, 0,  8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 1);
        vecs[1] = mk(1'b0, 8'h65, 8'h00, 2,  8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 3);
        vecs[2] = mk(1'b0, 8'h94, 8'h11, 0,  8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A, 1);
        vecs[3] = mk(1'b1, 8'h12, 8'hF0, 1,  8'h99, 1'b1, 1'b1, 1'b0, 8'h00, 2);
        vecs[4] = mk(1'b0, 8'h2D, 8'h00, 3,  8'hE7, 1'b0, 1'b0, 1'b0, 8'hE7, 4);
        vecs[5] = mk(1'b0, 8'hC8, 8'h00, 99, 8'h42, 1'b0, 1'b1, 1'b1, 8'h00, 4);
        vecs[6] = mk(1'b1, 8'h81, 8'h6E, 4,  8'h42, 1'b1, 1'b1, 1'b1, 8'h00, 4);

        // Reset state: every output low, even with a command waiting.
        p_rst = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hFF; cmd_wdata = 8'hFF;
        rd_data = 8'h00; p_ready = 1'b1; p_slverr = 1'b1;
        repeat (3) @(negedge p_clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_state", state, 0);
        check("rst_sel", p_sel, 0);
        check("rst_en", p_enable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_p_addr", p_addr, 0);
        check("rst_wr_data", wr_data, 0);
        cmd_valid = 1'b0; p_ready = 1'b0; p_slverr = 1'b0;
        p_rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: write 'h55 then read 'h76, cmd_valid held high.
        @(negedge p_clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'h3E;
        p_ready = 1'b1; p_slverr = 1'b0; rd_data = 8'h81;
        @(negedge p_clk);
        cmd_write = 1'b0; cmd_addr = 8'h76; cmd_wdata = 8'h00;
        #1;
        check("b2b_setup1_sel", p_sel, 1);
        check("b2b_setup1_en", p_enable, 0);
        check("b2b_setup1_addr", p_addr, 8'h55);
        check("b2b_setup1_ready", cmd_ready, 0);
        @(negedge p_clk);
        #1;
        check("b2b_acc1_en", p_enable, 1);
        check("b2b_acc1_ready", cmd_ready, 1);
        @(negedge p_clk);
        cmd_valid = 1'b0;
        #1;
        check("b2b_setup2_state", state, 1);
        check("b2b_setup2_sel", p_sel, 1);
        check("b2b_setup2_en", p_enable, 0);
        check("b2b_setup2_addr", p_addr, 8'h76);
        check("b2b_setup2_write", p_write, 0);
        check("b2b_rsp1_valid", rsp_valid, 1);
        check("b2b_rsp1_rdata", rsp_rdata, 0);
        check("b2b_rsp1_err", rsp_err, 0);
        @(negedge p_clk);
        #1;
        check("b2b_acc2_sel", p_sel, 1);
        check("b2b_acc2_en", p_enable, 1);
        check("b2b_gap_valid", rsp_valid, 0);
        @(negedge p_clk);
        p_ready = 1'b0;
        #1;
        check("b2b_rsp2_valid", rsp_valid, 1);
        check("b2b_rsp2_rdata", rsp_rdata, 8'h81);
        check("b2b_end_state", state, 0);
        check("b2b_end_sel", p_sel, 0);

        // Reset asserted between edges during ACCESS of a write.
        @(negedge p_clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h3A; cmd_wdata = 8'hC3; p_ready = 1'b0;
        @(negedge p_clk);
        cmd_valid = 1'b0;
        @(negedge p_clk);
        #1;
        check("mrst_pre_state", state, 2);
        #1;
        p_rst = 1'b1;
        #1;
        check("mrst_sel", p_sel, 0);
        check("mrst_en", p_enable, 0);
        check("mrst_state", state, 0);
        check("mrst_cmd_ready", cmd_ready, 0);
        check("mrst_rsp_valid", rsp_valid, 0);
        @(negedge p_clk);
        p_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge p_clk);
            #1;
            check("mrst_no_rsp", rsp_valid, 0);
            check("mrst_idle", state, 0);
        end
        run_xfer(vecs[1], "post_rst");

        // Random transfers against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            v.write  = 1'($urandom);
            v.addr   = AW'($urandom);
            v.wdata  = DW'($urandom);
            v.waits  = int'($urandom_range(0, 6));
            v.rdata  = DW'($urandom);
            v.slverr = 1'($urandom);
            run_xfer(predict(v), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester: the initiator end of the 8-bit APB link driven into the team's APB slave.
- Accepts single read/write commands on a valid/ready interface and runs the IDLE -> SETUP -> ACCESS sequence on the bus.
- Returns read data and error status on a one-cycle response pulse.
- Exposes its state encoding so the existing bind-style assertion modules can attach to it.

Parameters:
- A_WIDTH, 8, APB address width.
- D_WIDTH, 8, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for p_ready; 0 disables the timeout.

Ports:
- p_clk  in  1  bus clock; all logic on its rising edge.
- p_rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clock edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  A_WIDTH  transfer address.
- cmd_wdata  in  D_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  D_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  p_slverr seen, or timeout.
- rsp_timeout  out  1  transfer ended by timeout.
- p_sel  out  1  APB select.
- p_enable  out  1  APB enable.
- p_write  out  1  APB direction.
- p_addr  out  A_WIDTH  APB address.
- wr_data  out  D_WIDTH  APB write data.
- rd_data  in  D_WIDTH  APB read data.
- p_ready  in  1  slave ready; inserts wait states.
- p_slverr  in  1  slave error, valid with p_ready.
- state  out  2  current state: IDLE=0, SETUP=1, ACCESS=2; 3 is unused.

Behaviour:
- Reset: while p_rst=1, all outputs are 0, state=IDLE and the timeout counter is 0. Reset takes effect immediately, including mid-transfer. No response is issued for an aborted transfer.
- cmd_ready is high in IDLE, and in ACCESS during the cycle p_ready=1 (back-to-back acceptance). It is low otherwise.
- IDLE:
  - Outputs p_sel=0 and p_enable=0.
  - On accept, register cmd_write/cmd_addr/cmd_wdata into p_write/p_addr/wr_data and go to SETUP.
- SETUP:
  - Outputs p_sel=1 and p_enable=0.
  - Always goes to ACCESS on the next edge.
- ACCESS:
  - Outputs p_sel=1 and p_enable=1.
  - p_ready=0: stay in ACCESS and increment the wait counter.
  - p_ready=1: the transfer completes at this edge.
    - With a new command accepted at the same edge: go to SETUP with the new command registered; p_sel stays 1 and p_enable drops to 0.
    - Otherwise: go to IDLE.
- Stability: p_addr, p_write and wr_data hold from SETUP through the final ACCESS cycle. They change only at an accept edge. In IDLE they retain their last values.
- Latency: accept at edge N gives:
  - SETUP during cycle N+1 and ACCESS during N+2.
  - With zero wait states, rsp_valid=1 during N+3; minimum 3 cycles from accept to response.
- Response:
  - Registered; rsp_valid is exactly one cycle per completed transfer.
  - Read: rsp_rdata = rd_data sampled at the completing edge.
  - Write: rsp_rdata = 0.
  - rsp_err = p_slverr sampled at that edge; rsp_timeout = 0.
  - rsp_rdata, rsp_err and rsp_timeout are 0 whenever rsp_valid=0.
- Timeout (TIMEOUT_CYCLES>0):
  - Count ACCESS cycles with p_ready=0.
  - When the count reaches TIMEOUT_CYCLES and p_ready is still 0: terminate and go to IDLE (no back-to-back accept on a timeout).
  - Response: rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - The counter clears on every transition out of ACCESS.
- Simultaneous p_ready=1 and timeout threshold: p_ready wins and the transfer completes normally.
- p_slverr is ignored when p_ready=0.
- Unused state 3 is recovered to IDLE on the next edge with outputs deasserted.

Test Plan:
- Reset, then write addr 'h45 data 'hA5 with slave p_ready=1 immediately -> p_sel high 2 cycles, p_enable high 1 cycle, wr_data='hA5 throughout. rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read addr 'h65; slave holds p_ready=0 for 2 ACCESS cycles, then returns rd_data='h3C -> 3 ACCESS cycles with p_addr/p_write stable. rsp_rdata='h3C, rsp_err=0.
- Read addr 'h94 with p_slverr=1 alongside p_ready=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata equals sampled rd_data.
- Back-to-back: write 'h55 then read 'h76 with cmd_valid held continuously -> p_sel never drops between transfers. p_enable pattern 0,1,0,1; two rsp_valid pulses 2 cycles apart.
- TIMEOUT_CYCLES=4, slave never asserts p_ready -> exactly 4 ACCESS cycles, then IDLE. rsp_valid=1 with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Assert p_rst during ACCESS of a write -> p_sel/p_enable/state go to 0 immediately without waiting for a clock edge. No rsp_valid; after release, the next command runs normally.
